// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA host loader.
package rsa_pkg;

    localparam int unsigned DEFAULT_KEY_BITS = 256;
    localparam int unsigned DEFAULT_KEY_BYTES = DEFAULT_KEY_BITS / 8;

    // Cycles at the start of WAIT during which core_ready is ignored.
    localparam int unsigned WAIT_MASK = 2;
    localparam int unsigned WAIT_CNT_W = $clog2(WAIT_MASK + 1);

    typedef enum logic [2:0] {
        LOAD_N,
        LOAD_D,
        LOAD_M,
        START,
        WAIT,
        SEND
    } loader_state_e;

    function automatic int unsigned cnt_width(input int unsigned bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    localparam int unsigned BYTE_CNT_W = cnt_width(DEFAULT_KEY_BYTES);

endpackage

// File: rtl/rsa_byte_shifter.sv
// Wide register with parallel load and MSB-first byte shift (a byte enters at the bottom).
module rsa_byte_shifter #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic [7:0]       shift_in,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_en) begin
            data <= {data[WIDTH-9:0], shift_in};
        end
    end

endmodule

// File: rtl/rsa_host_loader.sv
// Byte-serial initiator for the modular-exponentiation core: loads N, d, M, runs the core,
// streams S back. Define RSA_HOST_LOADER_KEY_REUSE_EN to keep N and d across messages.
module rsa_host_loader
    import rsa_pkg::*;
#(
    parameter int unsigned KEY_BITS = DEFAULT_KEY_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                core_start,
    output logic [KEY_BITS-1:0] core_N,
    output logic [KEY_BITS-1:0] core_d,
    output logic [KEY_BITS-1:0] core_M,
    input  logic                core_ready,
    input  logic [KEY_BITS-1:0] core_S
);

    localparam int unsigned KEY_BYTES = KEY_BITS / 8;
    localparam int unsigned CNT_W = cnt_width(KEY_BYTES);

    loader_state_e         state, state_next;
    logic [CNT_W-1:0]      byte_cnt, byte_cnt_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic                  in_fire, out_fire, last_byte, capture;
    logic [KEY_BITS-1:0]   result;

    assign in_ready   = (state == LOAD_N) || (state == LOAD_D) || (state == LOAD_M);
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = (state == SEND);
    assign out_fire   = out_valid && out_ready;
    assign core_start = (state == START);
    assign last_byte  = (byte_cnt == CNT_W'(KEY_BYTES - 1));
    assign capture    = (state == WAIT) && (wait_cnt == WAIT_CNT_W'(WAIT_MASK)) && core_ready;
    assign out_data   = result[KEY_BITS-1 -: 8];

    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        wait_cnt_next = wait_cnt;

        if (in_fire || out_fire) begin
            byte_cnt_next = last_byte ? '0 : byte_cnt + CNT_W'(1);
        end

        case (state)
            LOAD_N: if (in_fire && last_byte) state_next = LOAD_D;
            LOAD_D: if (in_fire && last_byte) state_next = LOAD_M;
            LOAD_M: if (in_fire && last_byte) state_next = START;
            START: begin
                wait_cnt_next = '0;
                state_next    = WAIT;
            end
            WAIT: begin
                // Early core_ready may be left over from a previous run; skip it.
                if (wait_cnt != WAIT_CNT_W'(WAIT_MASK)) begin
                    wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
                end else if (core_ready) begin
                    byte_cnt_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (out_fire && last_byte) begin
`ifdef RSA_HOST_LOADER_KEY_REUSE_EN
                    state_next = LOAD_M;
`else
                    state_next = LOAD_N;
`endif
                end
            end
            default: state_next = LOAD_N;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD_N;
            byte_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    rsa_byte_shifter #(.WIDTH(KEY_BITS)) u_shift_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (in_fire && (state == LOAD_N)),
        .shift_in  (in_data),
        .data      (core_N)
    );

    rsa_byte_shifter #(.WIDTH(KEY_BITS)) u_shift_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (in_fire && (state == LOAD_D)),
        .shift_in  (in_data),
        .data      (core_d)
    );

    rsa_byte_shifter #(.WIDTH(KEY_BITS)) u_shift_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (in_fire && (state == LOAD_M)),
        .shift_in  (in_data),
        .data      (core_M)
    );

    rsa_byte_shifter #(.WIDTH(KEY_BITS)) u_shift_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_data (core_S),
        .shift_en  (out_fire),
        .shift_in  (8'h00),
        .data      (result)
    );

endmodule

// File: tb/tb_rsa_host_loader.sv
// Directed bench for rsa_host_loader with a behavioural exponentiation core.
module tb_rsa_host_loader;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         core_start;
    logic [255:0] core_N, core_d, core_M, core_S;
    logic         core_ready;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    bit key_loaded = 0;
    logic [255:0] rx;

`ifdef RSA_HOST_LOADER_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    rsa_host_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .core_start (core_start),
        .core_N     (core_N),
        .core_d     (core_d),
        .core_M     (core_M),
        .core_ready (core_ready),
        .core_S     (core_S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (core_start === 1'b1) start_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] modexp(input logic [255:0] n, input logic [255:0] e,
                                            input logic [255:0] m);
        logic [511:0] r, b, nn;
        nn = {256'd0, n};
        r  = 512'd1;
        b  = {256'd0, m} % nn;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[255:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick;
            g++;
        end
        if (!in_ready) chk("in_ready_timeout", {255'd0, in_ready}, 256'd1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [255:0] v, input int first, input int last,
                              input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                tick;
            end
            send_byte(v[255-8*i -: 8]);
        end
    endtask

    // N=33, d=7 always; N/d are skipped when the loader keeps the key.
    task automatic send_txn(input logic [255:0] m, input bit gaps_d);
        if (!(REUSE && key_loaded)) begin
            send_bytes(256'd33, 0, 31, 1'b0);
            send_bytes(256'd7, 0, 31, gaps_d);
        end
        send_bytes(m, 0, 30, 1'b0);
        tick;
        chk("no_start_before_last_m", {255'd0, core_start}, 256'd0);
        send_byte(m[7:0]);
        exp_starts++;
        chk("start_after_last_m", {255'd0, core_start}, 256'd1);
        chk("core_N", core_N, 256'd33);
        chk("core_d", core_d, 256'd7);
        chk("core_M", core_M, m);
        key_loaded = 1'b1;
    endtask

    task automatic core_reply(input int lat);
        core_ready = 1'b0;
        repeat (lat) tick;
        core_S     = modexp(core_N, core_d, core_M);
        core_ready = 1'b1;
    endtask

    task automatic recv(input bit toggle, output logic [255:0] val);
        int g, nb;
        bit held_v;
        logic [7:0] held;
        g = 0;
        nb = 0;
        held_v = 0;
        held = 8'h00;
        val = '0;
        out_ready = toggle ? 1'b0 : 1'b1;
        while (!out_valid && g < 100) begin
            tick;
            g++;
        end
        chk("out_valid_seen", {255'd0, out_valid}, 256'd1);
        core_ready = 1'b0;
        g = 0;
        while (nb < 32 && g < 300) begin
            if (out_valid) begin
                if (out_ready) begin
                    val = {val[247:0], out_data};
                    nb++;
                end else begin
                    held   = out_data;
                    held_v = 1'b1;
                end
            end
            tick;
            g++;
            if (held_v) begin
                chk("stall_hold", {248'd0, out_data}, {248'd0, held});
                held_v = 1'b0;
            end
            if (toggle) out_ready = ~out_ready;
        end
        chk("rx_count", 256'(nb), 256'd32);
        out_ready = 1'b1;
        chk("out_valid_after_send", {255'd0, out_valid}, 256'd0);
        chk("in_ready_after_send", {255'd0, in_ready}, 256'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        core_ready = 1'b0;
        core_S     = '0;
        tick;
        tick;
        chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst_out_data", {248'd0, out_data}, 256'd0);
        chk("rst_core_start", {255'd0, core_start}, 256'd0);
        chk("rst_core_N", core_N, 256'd0);
        chk("rst_core_d", core_d, 256'd0);
        chk("rst_core_M", core_M, 256'd0);
        rst_n = 1'b1;
        tick;

        // Basic: 2^7 mod 33 = 29
        send_txn(256'd2, 1'b0);
        tick;
        chk("start_one_cycle", {255'd0, core_start}, 256'd0);
        core_reply(3);
        recv(1'b0, rx);
        chk("basic_result", rx, 256'h1D);
        chk("basic_start_pulses", 256'(start_cnt), 256'd1);

        // Reset in the middle of SEND
        send_txn(256'd4, 1'b0);
        out_ready = 1'b0;
        core_reply(2);
        for (int g = 0; g < 50 && !out_valid; g++) tick;
        core_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) tick;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        chk("midrst_core_start", {255'd0, core_start}, 256'd0);
        chk("midrst_in_ready", {255'd0, in_ready}, 256'd1);
        chk("midrst_out_data", {248'd0, out_data}, 256'd0);
        chk("midrst_core_N", core_N, 256'd0);
        tick;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        key_loaded = 1'b0;
        tick;

        // Input gaps during LOAD_D: 5^7 mod 33 = 14
        send_txn(256'd5, 1'b1);
        core_reply(1);
        recv(1'b0, rx);
        chk("gaps_result", rx, 256'h0E);

        // Stale ready through START and the masked WAIT cycles: 4^7 mod 33 = 16
        send_txn(256'd4, 1'b0);
        core_S     = 256'hBAD;
        core_ready = 1'b1;
        repeat (3) tick;
        core_ready = 1'b0;
        core_S     = modexp(core_N, core_d, core_M);
        for (int i = 0; i < 5; i++) begin
            chk("stale_no_capture", {255'd0, out_valid}, 256'd0);
            tick;
        end
        core_ready = 1'b1;
        recv(1'b0, rx);
        chk("stale_result", rx, 256'h10);

        // Output backpressure: 8^7 mod 33 = 2
        send_txn(256'd8, 1'b0);
        core_reply(2);
        recv(1'b1, rx);
        chk("bp_result", rx, 256'h02);

`ifdef RSA_HOST_LOADER_KEY_REUSE_EN
        // Key kept: only M=3 is sent, 3^7 mod 33 = 9
        send_bytes(256'd3, 0, 31, 1'b0);
        exp_starts++;
        chk("reuse_start", {255'd0, core_start}, 256'd1);
        chk("reuse_core_N", core_N, 256'd33);
        chk("reuse_core_d", core_d, 256'd7);
        core_reply(2);
        recv(1'b0, rx);
        chk("reuse_result", rx, 256'h09);
`else
        // Without key reuse the next 32 bytes go to N
        send_bytes(256'hABCD, 0, 31, 1'b0);
        chk("reload_core_N", core_N, 256'hABCD);
        chk("reload_no_start", {255'd0, core_start}, 256'd0);
        chk("reload_in_ready", {255'd0, in_ready}, 256'd1);
`endif

        tick;
        chk("total_starts", 256'(start_cnt), 256'(exp_starts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
